// File: rtl/seq_multiplier_n_if.sv
// Handshake/operand bundle for seq_multiplier_n; SEQ_MUL_ACCUM_EN adds the accum request bit.
interface seq_multiplier_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   c;
`ifdef SEQ_MUL_ACCUM_EN
  logic                 accum;

  modport master (output start, sgn, a, b, accum, input busy, done, c);
  modport slave  (input start, sgn, a, b, accum, output busy, done, c);
`else
  modport master (output start, sgn, a, b, input busy, done, c);
  modport slave  (input start, sgn, a, b, output busy, done, c);
`endif
endinterface

// File: rtl/seq_multiplier_n.sv
// Shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock, MSB first.
// Define SEQ_MUL_ACCUM_EN to enable accumulate mode (c_new = c_prev + product).
module seq_multiplier_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  seq_multiplier_n_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nx;
  logic                 accept;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_mag, b_sh, a_abs, b_abs;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc, acc_nx, prod;
`ifdef SEQ_MUL_ACCUM_EN
  logic                 accum_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN:  if (cnt == LAST) state_nx = DONE;
      DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  // Signed operands become magnitudes here; -2^(W-1) maps to 2^(W-1), still representable unsigned.
  always_comb begin
    a_abs = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  always_comb begin
    acc_nx = {acc[2*WIDTH-2:0], 1'b0} + (b_sh[WIDTH-1] ? {{WIDTH{1'b0}}, a_mag} : '0);
    prod   = neg ? -acc_nx : acc_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      a_mag <= '0;
      b_sh  <= '0;
      neg   <= 1'b0;
      bus.c <= '0;
`ifdef SEQ_MUL_ACCUM_EN
      accum_r <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      acc   <= '0;
      a_mag <= a_abs;
      b_sh  <= b_abs;
      neg   <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef SEQ_MUL_ACCUM_EN
      accum_r <= bus.accum;
`endif
    end else if (state == RUN) begin
      acc  <= acc_nx;
      b_sh <= {b_sh[WIDTH-2:0], 1'b0};
      cnt  <= cnt + CW'(1);
      // Result is committed on the final iteration edge, i.e. on entry to DONE.
      if (cnt == LAST) begin
`ifdef SEQ_MUL_ACCUM_EN
        bus.c <= (accum_r ? bus.c : '0) + prod;
`else
        bus.c <= prod;
`endif
      end
    end
  end
endmodule
